// File: rtl/iter_alu_pkg.sv
// iter_alu_pkg: shared definitions for the iterative execute unit.
//   alu_op_e     - 4-bit ALU operation codes, the same values the ALU decoder emits
//   iter_state_e - control states of iter_alu
//   is_shift()   - true for the iterative shift operations
package iter_alu_pkg;

  typedef enum logic [3:0] {
    AluAdd   = 4'h0,
    AluSub   = 4'h1,
    AluAnd   = 4'h2,
    AluOr    = 4'h3,
    AluXor   = 4'h4,
    AluSlt   = 4'h5,
    AluSltu  = 4'h6,
    AluSll   = 4'h7,
    AluSrl   = 4'h8,
    AluSra   = 4'h9,
    AluCopyA = 4'hA,
    AluCopyB = 4'hB,
    AluXxx   = 4'hF
  } alu_op_e;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StShift = 2'd1,
    StDone  = 2'd2
  } iter_state_e;

  function automatic logic is_shift(input logic [3:0] op);
    return (op == AluSll) || (op == AluSrl) || (op == AluSra);
  endfunction

endpackage

// File: rtl/iter_alu_shifter.sv
// iter_alu_shifter: combinational single-step shifter used once per SHIFT cycle.
//   i_value [WIDTH]  - working value
//   i_step  [STEP_W] - bits to shift this cycle (0..SHIFT_STEP)
//   i_op    [4]      - AluSll / AluSrl / AluSra; anything else passes i_value through
//   o_value [WIDTH]  - shifted value
module iter_alu_shifter
  import iter_alu_pkg::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned STEP_W = 1
) (
  input  logic [WIDTH-1:0]  i_value,
  input  logic [STEP_W-1:0] i_step,
  input  logic [3:0]        i_op,
  output logic [WIDTH-1:0]  o_value
);

  always_comb begin
    o_value = i_value;
    case (i_op)
      AluSll:  o_value = i_value << i_step;
      AluSrl:  o_value = i_value >> i_step;
      // The working MSB stays equal to the original a[WIDTH-1] across steps,
      // so an arithmetic shift of the working value gives the right fill.
      AluSra:  o_value = $signed(i_value) >>> i_step;
      default: ;
    endcase
  end

endmodule

// File: rtl/iter_alu.sv
// iter_alu: multi-cycle execute unit with valid/ready handshakes.
// Logic/arithmetic ops finish on the accept edge; shifts iterate SHIFT_STEP bits per cycle.
//   i_clk, i_rst_n           - clock, synchronous active-low reset
//   i_in_valid, o_in_ready   - request handshake (i_alu_op, i_a, i_b captured on accept)
//   i_alu_op [4]             - ALU operation code
//   i_a, i_b [WIDTH]         - operands; shift amount is i_b[log2(WIDTH)-1:0]
//   o_out_valid, i_out_ready - result handshake
//   o_result [WIDTH]         - registered result, held while o_out_valid
//   o_busy                   - high in SHIFT or DONE
module iter_alu
  import iter_alu_pkg::*;
#(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned SHIFT_STEP = 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [3:0]       i_alu_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [WIDTH-1:0] o_result,
  output logic             o_busy
);

  localparam int unsigned ShamtW = $clog2(WIDTH);
  // One spare bit so SHIFT_STEP (up to 8) is representable next to the remaining count.
  localparam int unsigned CntW   = ShamtW + 1;
  localparam int unsigned StepW  = $clog2(SHIFT_STEP + 1);

  iter_state_e      r_state, w_state_next;
  logic [WIDTH-1:0] r_result, w_result_next;
  logic [WIDTH-1:0] r_work, w_work_next;
  logic [CntW-1:0]  r_remaining, w_remaining_next;
  logic [3:0]       r_op, w_op_next;

  logic [WIDTH-1:0] w_alu_res;
  logic [WIDTH-1:0] w_shifted;
  logic [CntW-1:0]  w_step_cnt;
  logic [CntW-1:0]  w_rem_after;
  logic [StepW-1:0] w_step;
  logic [ShamtW-1:0] w_shamt;

  assign w_shamt = i_b[ShamtW-1:0];

  // Single-cycle datapath, evaluated on the live inputs at the accept edge.
  always_comb begin
    w_alu_res = '0;
    case (i_alu_op)
      AluAdd:   w_alu_res = i_a + i_b;
      AluSub:   w_alu_res = i_a - i_b;
      AluAnd:   w_alu_res = i_a & i_b;
      AluOr:    w_alu_res = i_a | i_b;
      AluXor:   w_alu_res = i_a ^ i_b;
      AluSlt:   w_alu_res = {{(WIDTH-1){1'b0}}, ($signed(i_a) < $signed(i_b))};
      AluSltu:  w_alu_res = {{(WIDTH-1){1'b0}}, (i_a < i_b)};
      AluCopyA: w_alu_res = i_a;
      AluCopyB: w_alu_res = i_b;
      default:  w_alu_res = '0;
    endcase
  end

  // step = min(SHIFT_STEP, remaining); it always fits in StepW bits.
  assign w_step_cnt  = (r_remaining < CntW'(SHIFT_STEP)) ? r_remaining : CntW'(SHIFT_STEP);
  assign w_step      = w_step_cnt[StepW-1:0];
  assign w_rem_after = r_remaining - w_step_cnt;

  iter_alu_shifter #(
    .WIDTH  (WIDTH),
    .STEP_W (StepW)
  ) u_shifter (
    .i_value (r_work),
    .i_step  (w_step),
    .i_op    (r_op),
    .o_value (w_shifted)
  );

  always_comb begin
    w_state_next     = r_state;
    w_result_next    = r_result;
    w_work_next      = r_work;
    w_remaining_next = r_remaining;
    w_op_next        = r_op;
    unique case (r_state)
      StIdle: begin
        if (i_in_valid) begin
          w_op_next = i_alu_op;
          if (is_shift(i_alu_op)) begin
            w_work_next      = i_a;
            w_remaining_next = {1'b0, w_shamt};
            if (w_shamt == '0) begin
              w_result_next = i_a;
              w_state_next  = StDone;
            end else begin
              w_state_next  = StShift;
            end
          end else begin
            w_result_next = w_alu_res;
            w_state_next  = StDone;
          end
        end
      end
      StShift: begin
        w_work_next      = w_shifted;
        w_remaining_next = w_rem_after;
        if (w_rem_after == '0) begin
          w_result_next = w_shifted;
          w_state_next  = StDone;
        end
      end
      StDone: begin
        if (i_out_ready) w_state_next = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state     <= StIdle;
      r_result    <= '0;
      r_work      <= '0;
      r_remaining <= '0;
      r_op        <= '0;
    end else begin
      r_state     <= w_state_next;
      r_result    <= w_result_next;
      r_work      <= w_work_next;
      r_remaining <= w_remaining_next;
      r_op        <= w_op_next;
    end
  end

  assign o_in_ready  = (r_state == StIdle);
  assign o_out_valid = (r_state == StDone);
  assign o_busy      = (r_state == StShift) || (r_state == StDone);
  assign o_result    = r_result;

endmodule

// File: tb/tb_iter_alu.sv
// tb_iter_alu: directed self-checking bench for iter_alu.
// Two instances share all inputs: u_dut (SHIFT_STEP=1) and u_dut4 (SHIFT_STEP=4).
module tb_iter_alu;
  import iter_alu_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [3:0]  alu_op;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_ready;

  logic        in_ready, out_valid, busy;
  logic [31:0] result;
  logic        in_ready4, out_valid4, busy4;
  logic [31:0] result4;

  int n_checks = 0;
  int n_fail   = 0;

  iter_alu #(
    .WIDTH      (32),
    .SHIFT_STEP (1)
  ) u_dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_in_valid  (in_valid),
    .o_in_ready  (in_ready),
    .i_alu_op    (alu_op),
    .i_a         (a),
    .i_b         (b),
    .o_out_valid (out_valid),
    .i_out_ready (out_ready),
    .o_result    (result),
    .o_busy      (busy)
  );

  iter_alu #(
    .WIDTH      (32),
    .SHIFT_STEP (4)
  ) u_dut4 (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_in_valid  (in_valid),
    .o_in_ready  (in_ready4),
    .i_alu_op    (alu_op),
    .i_a         (a),
    .i_b         (b),
    .o_out_valid (out_valid4),
    .i_out_ready (out_ready),
    .o_result    (result4),
    .o_busy      (busy4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Issue one request with out_ready=1; latency counts the accept edge as cycle 1.
  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] va,
                        input logic [31:0] vb, input logic [31:0] exp, input int lat_exp,
                        input int lat4_exp);
    int lat;
    int lat4;
    logic [31:0] res;
    logic [31:0] res4;
    lat = 0; lat4 = 0; res = '0; res4 = '0;
    @(negedge clk);
    chk({tag, " in_ready"}, 32'(in_ready), 32'd1);
    chk({tag, " in_ready4"}, 32'(in_ready4), 32'd1);
    alu_op = op; a = va; b = vb; in_valid = 1'b1;
    @(posedge clk);
    #1;
    // Scramble inputs after accept: the unit must work from captured values.
    in_valid = 1'b0; alu_op = AluAdd; a = ~va; b = ~vb;
    for (int n = 1; n <= 100 && (lat == 0 || lat4 == 0); n++) begin
      @(negedge clk);
      if (lat == 0 && out_valid) begin lat = n; res = result; end
      if (lat4 == 0 && out_valid4) begin lat4 = n; res4 = result4; end
    end
    chk({tag, " latency"}, 32'(lat), 32'(lat_exp));
    chk({tag, " result"}, res, exp);
    chk({tag, " latency step4"}, 32'(lat4), 32'(lat4_exp));
    chk({tag, " result step4"}, res4, exp);
  endtask

  initial begin
    int stray;
    int bad_hold;
    int wait_n;
    rst_n = 1'b0; in_valid = 1'b0; alu_op = '0; a = '0; b = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset in_ready", 32'(in_ready), 32'd1);
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset result", result, 32'h0);
    rst_n = 1'b1;

    run_op("ADD wrap", AluAdd, 32'hFFFF_FFFF, 32'h1, 32'h0, 1, 1);
    run_op("SUB wrap", AluSub, 32'h0, 32'h1, 32'hFFFF_FFFF, 1, 1);
    run_op("OR", AluOr, 32'h0F00_0000, 32'h0000_00F0, 32'h0F00_00F0, 1, 1);
    run_op("AND", AluAnd, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1, 1);
    run_op("SLT", AluSlt, 32'h8000_0000, 32'h1, 32'h1, 1, 1);
    run_op("SLTU", AluSltu, 32'h8000_0000, 32'h1, 32'h0, 1, 1);
    run_op("SRA 31", AluSra, 32'h8000_0000, 32'd31, 32'hFFFF_FFFF, 32, 9);
    run_op("SRL 31", AluSrl, 32'h8000_0000, 32'd31, 32'h0000_0001, 32, 9);
    run_op("SRA pos", AluSra, 32'h4000_0000, 32'd4, 32'h0400_0000, 5, 2);
    run_op("SLL shamt0", AluSll, 32'h1, 32'h0000_0020, 32'h1, 1, 1);
    run_op("SLL 5", AluSll, 32'h1, 32'd5, 32'h20, 6, 3);
    run_op("SLL upper b", AluSll, 32'h1, 32'h0000_0123, 32'h8, 4, 2);
    run_op("XXX", AluXxx, 32'h1234_5678, 32'h1111_1111, 32'h0, 1, 1);
    run_op("undef op", 4'hC, 32'h1234_5678, 32'h1111_1111, 32'h0, 1, 1);
    run_op("COPY_A", AluCopyA, 32'hDEAD_BEEF, 32'h1234_5678, 32'hDEAD_BEEF, 1, 1);
    run_op("COPY_B", AluCopyB, 32'hDEAD_BEEF, 32'h1234_5678, 32'h1234_5678, 1, 1);

    // Backpressure: XOR result must hold for 10 cycles with out_ready low.
    @(negedge clk);
    out_ready = 1'b0;
    alu_op = AluXor; a = 32'hF0F0_F0F0; b = 32'h0FF0_0FF0; in_valid = 1'b1;
    @(posedge clk);
    #1;
    // A new request held while the unit is not ready must be ignored.
    alu_op = AluAdd; a = 32'd2; b = 32'd3;
    wait_n = 0;
    for (int n = 1; n <= 50; n++) begin
      @(negedge clk);
      if (out_valid) begin wait_n = n; break; end
    end
    chk("XOR latency", 32'(wait_n), 32'd1);
    bad_hold = 0;
    for (int n = 0; n < 10; n++) begin
      if (result !== 32'hFF00_FF00 || in_ready !== 1'b0 || out_valid !== 1'b1) bad_hold++;
      @(negedge clk);
    end
    chk("XOR held result", result, 32'hFF00_FF00);
    chk("XOR hold violations", 32'(bad_hold), 32'd0);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("post-handshake in_ready", 32'(in_ready), 32'd1);
    chk("post-handshake out_valid", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("held ADD out_valid", 32'(out_valid), 32'd1);
    chk("held ADD result", result, 32'd5);

    // Reset while mid-shift: no result may escape for the discarded op.
    @(negedge clk);
    out_ready = 1'b0;
    alu_op = AluSll; a = 32'h1; b = 32'd20; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid-shift busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst mid in_ready", 32'(in_ready), 32'd1);
    chk("rst mid out_valid", 32'(out_valid), 32'd0);
    chk("rst mid result", result, 32'h0);
    chk("rst mid busy", 32'(busy), 32'd0);
    chk("rst mid result step4", result4, 32'h0);
    rst_n = 1'b1;
    out_ready = 1'b1;
    stray = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid || out_valid4) stray++;
    end
    chk("stray out_valid after reset", 32'(stray), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
